vga_timing_gen: RTL
===================

# vga_timing_gen

Free-running VGA raster timing generator for the demo design. It produces the pixel coordinates, active-video flag, sync pulses and line/frame strobes that the demo core uses to compute each pixel's colour. The core's registered RGB/sync output stage then drives the pins. It sits directly upstream of the demo core and owns the pixel-rate decision: one pixel per clock, or one per two clocks.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48: horizontal front porch, sync and back porch, in pixels
- `V_ACTIVE`, 480: visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33: vertical front porch, sync and back porch, in lines
- `HSYNC_POL` / `VSYNC_POL`, 0 / 0: level of the sync signal while asserted (0 means active-low)
- `clk`  in  1  clock; one clock, all logic on its rising edge
- `rst_n`  in  1  reset; asynchronous and active-low
- `pix_en`  out  1  high during the first clk cycle in which a new pixel's outputs are valid
- `x`  out  $clog2(H_TOTAL)  horizontal position, 0..H_TOTAL-1
- `y`  out  $clog2(V_TOTAL)  vertical position, 0..V_TOTAL-1
- `active`  out  1  asserted when x < H_ACTIVE and y < V_ACTIVE
- `hsync`, `vsync`  out  1 each  sync outputs, polarity set by parameter
- `line_start`  out  1  high for the pixel x==0
- `frame_start`  out  1  high for the pixel x==0, y==0
- `frame_count`  out  8  frames started since reset, mod 256

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- An internal `tick` marks the clk edges on which the raster advances.
- Each axis runs a phase state machine in the order ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
  - Phase boundaries are at counts ACTIVE, ACTIVE+FP, ACTIVE+FP+SYNC and TOTAL.
  - The phase is held in a register and updated together with the count, not decoded combinationally at the output.
- Horizontal axis: x increments on each tick. At x==H_TOTAL-1, x wraps to 0 and the vertical axis advances by one line on the same edge.
- Vertical axis: y wraps from V_TOTAL-1 to 0. A simultaneous horizontal and vertical wrap starts a new frame.
- hsync is asserted while the horizontal phase is SYNC; vsync is asserted while the vertical phase is SYNC. vsync therefore changes only at x==0.
- On a frame start, frame_count increments and wraps 255 -> 0.
- All outputs are registered and describe the same pixel. There is no skew between x, y, active, the syncs and the strobes.

## Timing
- Reset values (asserted asynchronously):
  - x=0, y=0, frame_count=0
  - active=0, pix_en=0, line_start=0, frame_start=0
  - hsync=!HSYNC_POL, vsync=!VSYNC_POL (deasserted level)
- First tick after reset release presents pixel (0,0): active=1, line_start=1, frame_start=1, frame_count stays 0.
  - An internal "started" flag distinguishes this first tick from a normal advance.
  - frame_count increments only on later frame starts; after the first full frame it reads 1.
- pix_en is tick registered. It is high in the cycle immediately after each output update.
- Edges without a tick hold every output except pix_en.
- Frame period: H_TOTAL*V_TOTAL ticks (420000 by default).
- Deasserting rst_n mid-frame returns all outputs to their reset values immediately. Operation restarts at (0,0) on the first tick after release.

## Configuration
- `VGA_TIMING_PIXEL_DIV2_EN` defined:
  - tick alternates 1,0,1,0..., with 1 on the first clk edge after reset release.
  - One pixel per two clocks; pix_en toggles every cycle.
  - Frame period is 840000 clocks.
- Not defined:
  - tick=1 on every edge after release.
  - pix_en is constantly 1 from the cycle after the first edge.
  - One pixel per clock.

## Structure
- Package `vga_timing_pkg` holds:
  - the phase typedef (PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK)
  - the default 640x480 timing constants
- Sub-module `vga_axis_counter`, instantiated twice (horizontal and vertical):
  - Parameters: ACTIVE, FP, SYNC, BP.
  - Inputs: `clk`, `rst_n`, `advance`.
  - Outputs: `count`, `phase`, `wrap` (combinational: advance && count==TOTAL-1).
  - The top block chains the horizontal `wrap` into the vertical `advance`, then adds the tick/pix_en generation, sync polarity, strobes and frame_count.

## Test plan
- Reset: rst_n=0 -> x=0, y=0, hsync=1, vsync=1, active=0, pix_en=0, frame_count=0. Release and first tick -> (0,0), active=1, line_start=1, frame_start=1.
- Horizontal sweep, no DIV2: hsync low exactly for x=656..751. active drops at x=640. At x=799 the next tick gives x=0, y+1, line_start=1.
- Vertical sweep: vsync low exactly for y=490..491, each change aligned with x==0. active=0 for y>=480. Transition (799,524) -> (0,0) gives frame_start=1.
- frame_count: run 256 full frames after the first -> value sequence 1..255 then 0. The strobe coincides with the increment.
- DIV2 build: pix_en alternates 1,0. Outputs change only on alternate edges. Two consecutive frame_start pulses are 840000 clocks apart.
- Reset mid-frame at (300,200): asynchronous return to reset values without a clock edge. Restart at (0,0) with frame_count=0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared phase type and default 640x480@60 raster constants
// for the VGA timing generator and its axis counters.
package vga_timing_pkg;

  // Position of one raster axis within its line or frame.
  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  // Default 640x480 timing, in pixels (horizontal) and lines (vertical).
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical). Holds the
// position that will be presented on the next advance, together with its
// phase register, so the phase never has to be decoded from the count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  localparam int TOTAL = ACTIVE + FP + SYNC + BP,
  localparam int W     = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         advance,
  output logic [W-1:0] count,
  output phase_t       phase,
  output logic         wrap
);

  // Last count of each phase; crossing it moves to the following phase.
  localparam logic [W-1:0] END_ACTIVE = W'(ACTIVE - 1);
  localparam logic [W-1:0] END_FRONT  = W'(ACTIVE + FP - 1);
  localparam logic [W-1:0] END_SYNC   = W'(ACTIVE + FP + SYNC - 1);
  localparam logic [W-1:0] END_TOTAL  = W'(TOTAL - 1);

  logic [W-1:0] count_nxt_s;
  phase_t       phase_nxt_s;

  assign wrap = advance && (count == END_TOTAL);

  // Next count and phase: step on advance, otherwise hold.
  always_comb begin
    count_nxt_s = count;
    phase_nxt_s = phase;
    if (advance) begin
      if (count == END_TOTAL) begin
        count_nxt_s = {W{1'b0}};
      end else begin
        count_nxt_s = count + 1'b1;
      end
      case (phase)
        PH_ACTIVE: begin
          if (count == END_ACTIVE) phase_nxt_s = PH_FRONT;
          else                     phase_nxt_s = PH_ACTIVE;
        end
        PH_FRONT: begin
          if (count == END_FRONT) phase_nxt_s = PH_SYNC;
          else                    phase_nxt_s = PH_FRONT;
        end
        PH_SYNC: begin
          if (count == END_SYNC) phase_nxt_s = PH_BACK;
          else                   phase_nxt_s = PH_SYNC;
        end
        PH_BACK: begin
          if (count == END_TOTAL) phase_nxt_s = PH_ACTIVE;
          else                    phase_nxt_s = PH_BACK;
        end
        default: phase_nxt_s = PH_ACTIVE;
      endcase
    end else begin
      count_nxt_s = count;
      phase_nxt_s = phase;
    end
  end

  // Count and phase registers, updated together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {W{1'b0}};
      phase <= PH_ACTIVE;
    end else begin
      count <= count_nxt_s;
      phase <= phase_nxt_s;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing generator.
// Optional build macro VGA_TIMING_PIXEL_DIV2_EN: one pixel per two clocks
// instead of one pixel per clock.
// The axis counters run one pixel ahead of the outputs: each tick copies the
// counter state into the output registers while the counters step on, so
// every output describes the same pixel with no skew.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW        = $clog2(H_TOTAL),
  localparam int YW        = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          pix_en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_count
);

  logic          tick_s;
  logic [XW-1:0] h_count_s;
  logic [YW-1:0] v_count_s;
  phase_t        h_phase_s;
  phase_t        v_phase_s;
  logic          h_wrap_s;
  logic          v_wrap_s;
  logic          started_r;
  logic          frame_pending_r;

`ifdef VGA_TIMING_PIXEL_DIV2_EN
  logic div_r;

  // Divide-by-two phase; low on the first edge after release so it ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= 1'b0;
    end else begin
      div_r <= ~div_r;
    end
  end

  assign tick_s = ~div_r;
`else
  assign tick_s = 1'b1;
`endif

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (tick_s),
    .count   (h_count_s),
    .phase   (h_phase_s),
    .wrap    (h_wrap_s)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (h_wrap_s),
    .count   (v_count_s),
    .phase   (v_phase_s),
    .wrap    (v_wrap_s)
  );

  // Output registers: load the pending pixel on each tick; pix_en follows tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_en          <= 1'b0;
      x               <= {XW{1'b0}};
      y               <= {YW{1'b0}};
      active          <= 1'b0;
      hsync           <= ~HSYNC_POL;
      vsync           <= ~VSYNC_POL;
      line_start      <= 1'b0;
      frame_start     <= 1'b0;
      frame_count     <= 8'd0;
      started_r       <= 1'b0;
      frame_pending_r <= 1'b0;
    end else begin
      pix_en <= tick_s;
      if (tick_s) begin
        x           <= h_count_s;
        y           <= v_count_s;
        active      <= (h_phase_s == PH_ACTIVE) && (v_phase_s == PH_ACTIVE);
        hsync       <= (h_phase_s == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
        vsync       <= (v_phase_s == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
        line_start  <= (h_count_s == {XW{1'b0}});
        // The very first pixel after release is a frame start that does not count.
        frame_start <= frame_pending_r || !started_r;
        if (frame_pending_r) begin
          frame_count <= frame_count + 8'd1;
        end else begin
          frame_count <= frame_count;
        end
        started_r       <= 1'b1;
        frame_pending_r <= v_wrap_s;
      end else begin
        x               <= x;
        y               <= y;
        active          <= active;
        hsync           <= hsync;
        vsync           <= vsync;
        line_start      <= line_start;
        frame_start     <= frame_start;
        frame_count     <= frame_count;
        started_r       <= started_r;
        frame_pending_r <= frame_pending_r;
      end
    end
  end

endmodule
